// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch squash,
// downstream freeze and a saturating count of inserted load-use bubbles.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_raddr1,
    input  logic [4:0]       id_raddr2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_waddr,
    input  logic [XLEN-1:0]  id_rdata1,
    input  logic [XLEN-1:0]  id_rdata2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [XLEN-1:0]  id_pc,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             id_alu_src,
    input  logic             id_branch,
    input  logic [3:0]       id_alu_op,
    input  logic             ex_flush,
    input  logic             ext_stall,
    input  logic             clr_cnt,
    output logic             id_ex_valid,
    output logic [4:0]       id_ex_raddr1,
    output logic [4:0]       id_ex_raddr2,
    output logic [4:0]       id_ex_waddr,
    output logic [XLEN-1:0]  id_ex_rdata1,
    output logic [XLEN-1:0]  id_ex_rdata2,
    output logic [XLEN-1:0]  id_ex_imm,
    output logic [XLEN-1:0]  id_ex_pc,
    output logic             id_ex_reg_write,
    output logic             id_ex_mem_read,
    output logic             id_ex_mem_write,
    output logic             id_ex_mem_to_reg,
    output logic             id_ex_alu_src,
    output logic             id_ex_branch,
    output logic [3:0]       id_ex_alu_op,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic [CNT_W-1:0] stall_cnt
);

    logic load_use;
    logic bubble;
    logic count_evt;
    logic front_en;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        load_use = id_ex_valid & id_ex_mem_read & (id_ex_waddr != 5'd0) & id_valid &
                   ((id_uses_rs1 & (id_raddr1 == id_ex_waddr)) |
                    (id_uses_rs2 & (id_raddr2 == id_ex_waddr)));
        // Flush beats freeze; freeze beats the load-use bubble.
        count_evt = load_use & ~ext_stall & ~ex_flush;
        bubble    = ex_flush | count_evt;
        front_en  = ~(ext_stall | (load_use & ~ex_flush));
    end

    assign pc_write_en    = front_en;
    assign if_id_write_en = front_en;

    // ---- ID -> EX register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_valid      <= 1'b0;
            id_ex_raddr1     <= '0;
            id_ex_raddr2     <= '0;
            id_ex_waddr      <= '0;
            id_ex_rdata1     <= '0;
            id_ex_rdata2     <= '0;
            id_ex_imm        <= '0;
            id_ex_pc         <= '0;
            id_ex_reg_write  <= 1'b0;
            id_ex_mem_read   <= 1'b0;
            id_ex_mem_write  <= 1'b0;
            id_ex_mem_to_reg <= 1'b0;
            id_ex_alu_src    <= 1'b0;
            id_ex_branch     <= 1'b0;
            id_ex_alu_op     <= '0;
        end else if (bubble) begin
            id_ex_valid      <= 1'b0;
            id_ex_raddr1     <= '0;
            id_ex_raddr2     <= '0;
            id_ex_waddr      <= '0;
            id_ex_rdata1     <= '0;
            id_ex_rdata2     <= '0;
            id_ex_imm        <= '0;
            id_ex_pc         <= '0;
            id_ex_reg_write  <= 1'b0;
            id_ex_mem_read   <= 1'b0;
            id_ex_mem_write  <= 1'b0;
            id_ex_mem_to_reg <= 1'b0;
            id_ex_alu_src    <= 1'b0;
            id_ex_branch     <= 1'b0;
            id_ex_alu_op     <= '0;
        end else if (!ext_stall) begin
            // Control bits of an invalid slot are forced low so a hole never writes.
            id_ex_valid      <= id_valid;
            id_ex_raddr1     <= id_raddr1;
            id_ex_raddr2     <= id_raddr2;
            id_ex_waddr      <= id_waddr;
            id_ex_rdata1     <= id_rdata1;
            id_ex_rdata2     <= id_rdata2;
            id_ex_imm        <= id_imm;
            id_ex_pc         <= id_pc;
            id_ex_reg_write  <= id_reg_write  & id_valid;
            id_ex_mem_read   <= id_mem_read   & id_valid;
            id_ex_mem_write  <= id_mem_write  & id_valid;
            id_ex_mem_to_reg <= id_mem_to_reg & id_valid;
            id_ex_alu_src    <= id_alu_src    & id_valid;
            id_ex_branch     <= id_branch     & id_valid;
            id_ex_alu_op     <= id_alu_op     & {4{id_valid}};
        end
    end

    // ---- bubble counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
        end else if (count_evt) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural model.
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk, rst_n;
    logic             id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0]       id_raddr1, id_raddr2, id_waddr;
    logic [XLEN-1:0]  id_rdata1, id_rdata2, id_imm, id_pc;
    logic             id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch;
    logic [3:0]       id_alu_op;
    logic             ex_flush, ext_stall, clr_cnt;
    logic             id_ex_valid;
    logic [4:0]       id_ex_raddr1, id_ex_raddr2, id_ex_waddr;
    logic [XLEN-1:0]  id_ex_rdata1, id_ex_rdata2, id_ex_imm, id_ex_pc;
    logic             id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_alu_src, id_ex_branch;
    logic [3:0]       id_ex_alu_op;
    logic             pc_write_en, if_id_write_en;
    logic [CNT_W-1:0] stall_cnt;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_waddr(id_waddr),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc(id_pc),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_branch(id_branch),
        .id_alu_op(id_alu_op), .ex_flush(ex_flush), .ext_stall(ext_stall), .clr_cnt(clr_cnt),
        .id_ex_valid(id_ex_valid), .id_ex_raddr1(id_ex_raddr1), .id_ex_raddr2(id_ex_raddr2),
        .id_ex_waddr(id_ex_waddr), .id_ex_rdata1(id_ex_rdata1), .id_ex_rdata2(id_ex_rdata2),
        .id_ex_imm(id_ex_imm), .id_ex_pc(id_ex_pc), .id_ex_reg_write(id_ex_reg_write),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_mem_write(id_ex_mem_write),
        .id_ex_mem_to_reg(id_ex_mem_to_reg), .id_ex_alu_src(id_ex_alu_src),
        .id_ex_branch(id_ex_branch), .id_ex_alu_op(id_ex_alu_op),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the stage contents as one record, plus a bubble tally.
    typedef struct packed {
        logic            valid;
        logic [4:0]      raddr1, raddr2, waddr;
        logic [XLEN-1:0] rdata1, rdata2, imm, pc;
        logic            reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch;
        logic [3:0]      alu_op;
    } stage_t;

    stage_t m;
    int     m_cnt;

    function automatic bit model_hazard();
        return m.valid && m.mem_read && (m.waddr != 0) && id_valid &&
               ((id_uses_rs1 && id_raddr1 == m.waddr) || (id_uses_rs2 && id_raddr2 == m.waddr));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m     = '0;
            m_cnt = 0;
        end else begin
            bit hz;
            hz = model_hazard();
            if (clr_cnt)
                m_cnt = 0;
            else if (hz && !ext_stall && !ex_flush)
                m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
            if (ex_flush || (hz && !ext_stall)) begin
                m = '0;
            end else if (!ext_stall) begin
                m.valid  = id_valid;
                m.raddr1 = id_raddr1;  m.raddr2 = id_raddr2;  m.waddr = id_waddr;
                m.rdata1 = id_rdata1;  m.rdata2 = id_rdata2;
                m.imm    = id_imm;     m.pc     = id_pc;
                m.reg_write  = id_valid ? id_reg_write  : 1'b0;
                m.mem_read   = id_valid ? id_mem_read   : 1'b0;
                m.mem_write  = id_valid ? id_mem_write  : 1'b0;
                m.mem_to_reg = id_valid ? id_mem_to_reg : 1'b0;
                m.alu_src    = id_valid ? id_alu_src    : 1'b0;
                m.branch     = id_valid ? id_branch     : 1'b0;
                m.alu_op     = id_valid ? id_alu_op     : 4'd0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_en;
            exp_en = !(ext_stall || (model_hazard() && !ex_flush));
            chk("ctrl", 64'({id_ex_valid, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
                             id_ex_mem_to_reg, id_ex_alu_src, id_ex_branch, id_ex_alu_op}),
                        64'({m.valid, m.reg_write, m.mem_read, m.mem_write,
                             m.mem_to_reg, m.alu_src, m.branch, m.alu_op}));
            chk("addr", 64'({id_ex_raddr1, id_ex_raddr2, id_ex_waddr}),
                        64'({m.raddr1, m.raddr2, m.waddr}));
            chk("rdata", {id_ex_rdata1, id_ex_rdata2}, {m.rdata1, m.rdata2});
            chk("imm_pc", {id_ex_imm, id_ex_pc}, {m.imm, m.pc});
            chk("pc_write_en", 64'(pc_write_en), 64'(exp_en));
            chk("if_id_write_en", 64'(if_id_write_en), 64'(exp_en));
            chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic mr, input logic rw);
        id_valid = v;  id_raddr1 = rs1;  id_raddr2 = rs2;
        id_uses_rs1 = u1;  id_uses_rs2 = u2;  id_waddr = rd;
        id_mem_read = mr;  id_reg_write = rw;  id_mem_to_reg = mr;  id_alu_src = mr;
        id_mem_write = 1'b0;  id_branch = 1'b0;  id_alu_op = 4'($urandom_range(0, 15));
        id_rdata1 = $urandom;  id_rdata2 = $urandom;  id_imm = $urandom;  id_pc = $urandom;
    endtask

    initial begin
        rst_n = 1'b0;  ex_flush = 1'b0;  ext_stall = 1'b0;  clr_cnt = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 64'(id_ex_valid), 64'(0));
        chk("reset_cnt", 64'(stall_cnt), 64'(0));
        chk("reset_pc_we", 64'(pc_write_en), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // lw x5,0(x1) ; add x6,x5,x2
        tick(); drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        tick(); drive(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1);
        #3; chk("lu_pc_we", 64'(pc_write_en), 64'(0));
        tick(); #3;
        chk("lu_bubble_valid", 64'(id_ex_valid), 64'(0));
        chk("lu_bubble_rw", 64'(id_ex_reg_write), 64'(0));
        chk("lu_cnt", 64'(stall_cnt), 64'(1));
        chk("lu_pc_we_after", 64'(pc_write_en), 64'(1));
        tick(); drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);   // lw x0
        #3; chk("add_in_ex", 64'({id_ex_valid, id_ex_waddr}), 64'({1'b1, 5'd6}));
        tick(); drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1);   // reader of x0
        #3; chk("x0_no_stall", 64'(pc_write_en), 64'(1));
        tick(); drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5
        #3; chk("x0_reader_in_ex", 64'({id_ex_valid, id_ex_waddr, stall_cnt}), 64'({1'b1, 5'd7, 4'd1}));
        tick(); drive(1'b1, 5'd5, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1);   // rs1 field 5 but unused
        #3; chk("unused_rs1_no_stall", 64'(pc_write_en), 64'(1));
        tick(); drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);   // lw x9
        #3; chk("unused_rs1_in_ex", 64'({id_ex_waddr, stall_cnt}), 64'({5'd8, 4'd1}));

        // Freeze with a pending load-use
        tick(); drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b0, 1'b1);
        ext_stall = 1'b1;
        #3; chk("freeze_pc_we", 64'(pc_write_en), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) ext_stall = 1'b0;
            #3; chk("freeze_hold", 64'({id_ex_valid, id_ex_mem_read, id_ex_waddr, stall_cnt}),
                                   64'({1'b1, 1'b1, 5'd9, 4'd1}));
        end
        tick(); #3;
        chk("freeze_release_bubble", 64'({id_ex_valid, stall_cnt}), 64'({1'b0, 4'd2}));
        tick(); #3;
        chk("freeze_dep_in_ex", 64'({id_ex_valid, id_ex_waddr}), 64'({1'b1, 5'd10}));

        // Flush together with load-use, then flush together with ext_stall
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b1);
        tick(); drive(1'b1, 5'd11, 5'd0, 1'b1, 1'b0, 5'd12, 1'b0, 1'b1);
        ex_flush = 1'b1;
        #3; chk("flush_lu_pc_we", 64'(pc_write_en), 64'(1));
        tick(); ex_flush = 1'b0;
        #3; chk("flush_lu_bubble", 64'({id_ex_valid, stall_cnt}), 64'({1'b0, 4'd2}));
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd13, 1'b0, 1'b1);
        tick(); ex_flush = 1'b1; ext_stall = 1'b1;
        #3; chk("flush_stall_pre", 64'({id_ex_valid, id_ex_waddr}), 64'({1'b1, 5'd13}));
        tick(); ex_flush = 1'b0; ext_stall = 1'b0;
        #3; chk("flush_stall_bubble", 64'({id_ex_valid, id_ex_reg_write}), 64'(0));

        // Saturation: 17 load-use events on a 4-bit counter
        clr_cnt = 1'b1;
        tick(); clr_cnt = 1'b0;
        #3; chk("clr_cnt", 64'(stall_cnt), 64'(0));
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
            tick(); drive(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1);
            tick(); tick();
        end
        #3; chk("sat_cnt", 64'(stall_cnt), 64'(15));

        // Reset in the middle of a pending stall
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        tick(); drive(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1);
        #2; rst_n = 1'b0;
        #1; chk("midreset_state", 64'({id_ex_valid, id_ex_mem_read, id_ex_waddr, stall_cnt}), 64'(0));
        chk("midreset_data", {id_ex_rdata1, id_ex_pc}, 64'(0));
        chk("midreset_pc_we", 64'(pc_write_en), 64'(1));
        @(negedge clk); rst_n = 1'b1;

        // clr_cnt coinciding with a load-use event
        tick(); drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        tick(); drive(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1);
        clr_cnt = 1'b1;
        tick(); clr_cnt = 1'b0;
        #3; chk("clr_with_event", 64'({id_ex_valid, stall_cnt}), 64'(0));

        // Random traffic over a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            tick();
            drive(1'($urandom_range(0, 4) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
            id_mem_write = 1'($urandom_range(0, 1));
            id_branch    = 1'($urandom_range(0, 1));
            ext_stall    = ($urandom_range(0, 99) < 15);
            ex_flush     = ($urandom_range(0, 99) < 10);
            clr_cnt      = ($urandom_range(0, 99) < 3);
        end
        tick();
        ext_stall = 1'b0; ex_flush = 1'b0; clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
